video_timing_gen: RTL and testbench

Raster timing generator producing the vs/hs/de sync stream consumed by the line-detection and line-buffer logic downstream. It counts pixel clocks into horizontal and vertical positions from parameterised porch/sync/active widths, and emits registered sync pulses, data-enable and active-pixel coordinates. Start and stop are frame-aligned: an enable request starts a fresh frame, and a de-assert finishes the current frame before idling.

---
 rtl/video_timing_gen.sv | 165 ++++++++++++++++
 tb/tb_video_timing_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters, registered active-low syncs, data-enable and active coordinates.
// Optional active-line group counter on line_grp when VTG_LINE_GROUP_EN is defined.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE   = 1280,
  parameter int unsigned H_FP       = 110,
  parameter int unsigned H_SYNC     = 40,
  parameter int unsigned H_BP       = 220,
  parameter int unsigned V_ACTIVE   = 720,
  parameter int unsigned V_FP       = 5,
  parameter int unsigned V_SYNC     = 5,
  parameter int unsigned V_BP       = 20,
  parameter int unsigned LINE_GROUP = 45
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic        busy,
  output logic        vs,
  output logic        hs,
  output logic        de,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        frame_start
`ifdef VTG_LINE_GROUP_EN
  ,
  output logic [5:0]  line_grp
`endif
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  // Region bounds are 13 bits wide so an end bound equal to 4096 still compares correctly.
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [12:0] HS_END   = 13'(H_SYNC);
  localparam logic [12:0] VS_END   = 13'(V_SYNC);
  localparam logic [12:0] HA_START = 13'(H_SYNC + H_BP);
  localparam logic [12:0] HA_END   = 13'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [12:0] VA_START = 13'(V_SYNC + V_BP);
  localparam logic [12:0] VA_END   = 13'(V_SYNC + V_BP + V_ACTIVE);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [11:0] h_cnt, v_cnt;
  logic [11:0] h_next, v_next;
  logic        frame_last;

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      state <= state_next;
      h_cnt <= h_next;
      v_cnt <= v_next;
    end
  end

  assign frame_last = (h_cnt == H_LAST) && (v_cnt == V_LAST);

  // Next state and next counter values
  always_comb begin
    state_next = state;
    h_next     = h_cnt;
    v_next     = v_cnt;
    case (state)
      IDLE: begin
        h_next = '0;
        v_next = '0;
        if (en) state_next = RUN;
      end
      RUN, STOPPING: begin
        if (h_cnt == H_LAST) begin
          h_next = '0;
          v_next = (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end else begin
          h_next = h_cnt + 12'd1;
        end
        // A stop request only takes effect once the current frame has finished.
        if (en)              state_next = RUN;
        else if (frame_last) state_next = IDLE;
        else                 state_next = STOPPING;
      end
      default: begin
        state_next = IDLE;
        h_next     = '0;
        v_next     = '0;
      end
    endcase
  end

  logic        running;
  logic        h_act, v_act;
  logic        busy_d, vs_d, hs_d, de_d, frame_start_d;
  logic [11:0] x_d, y_d;

  // Output decode from the next-state counters so outputs move on the same edge as the counters
  always_comb begin
    running       = (state_next != IDLE);
    h_act         = ({1'b0, h_next} >= HA_START) && ({1'b0, h_next} < HA_END);
    v_act         = ({1'b0, v_next} >= VA_START) && ({1'b0, v_next} < VA_END);
    busy_d        = running;
    hs_d          = !(running && ({1'b0, h_next} < HS_END));
    vs_d          = !(running && ({1'b0, v_next} < VS_END));
    de_d          = running && h_act && v_act;
    x_d           = de_d ? (h_next - HA_START[11:0]) : 12'd0;
    y_d           = (running && v_act) ? (v_next - VA_START[11:0]) : 12'd0;
    frame_start_d = running && (h_next == 12'd0) && (v_next == 12'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      vs          <= 1'b1;
      hs          <= 1'b1;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      busy        <= busy_d;
      vs          <= vs_d;
      hs          <= hs_d;
      de          <= de_d;
      x           <= x_d;
      y           <= y_d;
      frame_start <= frame_start_d;
    end
  end

`ifdef VTG_LINE_GROUP_EN
  localparam logic [5:0] LG_MAX = 6'(LINE_GROUP);

  logic [5:0] line_grp_d;

  // Group index restarts at 1 on each frame's first active line and advances at each line start
  always_comb begin
    line_grp_d = line_grp;
    if (!running) begin
      line_grp_d = '0;
    end else if (h_next == 12'd0) begin
      if (!v_act)
        line_grp_d = '0;
      else if ({1'b0, v_next} == VA_START || line_grp >= LG_MAX)
        line_grp_d = 6'd1;
      else
        line_grp_d = line_grp + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) line_grp <= '0;
    else       line_grp <= line_grp_d;
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: directed start/stop/reset steps plus randomized en,
// compared every clock against a frame-position reference model.
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int LG = 3;
  localparam int HT = HS + HB + HA + HF;   // 14
  localparam int VT = VS + VB + VA + VF;   // 7
  localparam int FT = HT * VT;             // 98 clocks per frame

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        busy, vs, hs, de, frame_start;
  logic [11:0] x, y;
`ifdef VTG_LINE_GROUP_EN
  logic [5:0]  line_grp;
`endif

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .LINE_GROUP(LG)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .busy(busy),
    .vs(vs),
    .hs(hs),
    .de(de),
    .x(x),
    .y(y),
    .frame_start(frame_start)
`ifdef VTG_LINE_GROUP_EN
    ,
    .line_grp(line_grp)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: running flag plus clock position within the frame.
  bit m_run = 1'b0;
  int m_t   = 0;

  int de_cnt = 0;
  int fs_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d run=%0d)", tag, obs, exp, m_t, m_run);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_run = 1'b0;
      m_t   = 0;
    end else if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_t   = 0;
      end
    end else if (m_t == FT - 1 && !en) begin
      m_run = 1'b0;
      m_t   = 0;
    end else begin
      m_t = (m_t + 1) % FT;
    end
  endtask

  task automatic check_all();
    int  h, v, ex, ey, elg;
    bit  hact, vact, ede;
    h    = m_t % HT;
    v    = m_t / HT;
    hact = (h >= HS + HB) && (h < HS + HB + HA);
    vact = (v >= VS + VB) && (v < VS + VB + VA);
    ede  = m_run && hact && vact;
    ex   = ede ? h - (HS + HB) : 0;
    ey   = (m_run && vact) ? v - (VS + VB) : 0;
    elg  = (m_run && vact) ? ((v - (VS + VB)) % LG) + 1 : 0;
    chk("busy", 32'(busy), 32'(m_run));
    chk("hs", 32'(hs), 32'(!(m_run && h < HS)));
    chk("vs", 32'(vs), 32'(!(m_run && v < VS)));
    chk("de", 32'(de), 32'(ede));
    chk("x", 32'(x), 32'(ex));
    chk("y", 32'(y), 32'(ey));
    chk("frame_start", 32'(frame_start), 32'(m_run && m_t == 0));
`ifdef VTG_LINE_GROUP_EN
    chk("line_grp", 32'(line_grp), 32'(elg));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (de === 1'b1) de_cnt++;
    if (frame_start === 1'b1) fs_cnt++;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the model reaches the given frame position (bounded by one frame).
  task automatic goto_pos(input int target);
    for (int i = 0; i <= FT && !(m_run && m_t == target); i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    #2;
    check_all();
    run(3);
    reset = 1'b0;

    // Idle with en low
    run(50);
    chk("idle_busy", 32'(busy), 32'd0);

    // Start: frame_start on the first edge after en rises
    en = 1'b1;
    tick();
    chk("start_fs", 32'(frame_start), 32'd1);
    chk("start_vs", 32'(vs), 32'd0);
    chk("start_hs", 32'(hs), 32'd0);
    de_cnt = 0;
    fs_cnt = 0;
    run(2 * FT);
    chk("de_per_2frames", 32'(de_cnt), 32'd64);
    chk("fs_per_2frames", 32'(fs_cnt), 32'd2);
    chk("fs_period", 32'(frame_start), 32'd1);

    // Drop en at clock 30: frame completes, then idle
    goto_pos(30);
    en = 1'b0;
    run(FT - 1 - 30);
    chk("stop_last_busy", 32'(busy), 32'd1);
    tick();
    chk("stop_idle_busy", 32'(busy), 32'd0);
    chk("stop_idle_vs", 32'(vs), 32'd1);
    run(20);

    // Drop at 30, re-raise at 60: frames continue without a gap
    en = 1'b1;
    tick();
    goto_pos(30);
    en = 1'b0;
    goto_pos(60);
    en = 1'b1;
    fs_cnt = 0;
    run(FT + 10);
    chk("resume_fs", 32'(fs_cnt), 32'd1);
    chk("resume_busy", 32'(busy), 32'd1);

    // Asynchronous reset mid-frame at clock 40
    goto_pos(40);
    reset = 1'b1;
    #1;
    m_run = 1'b0;
    m_t   = 0;
    check_all();
    chk("rst_busy", 32'(busy), 32'd0);
    run(3);
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b0;
    run(5);
    en = 1'b1;
    tick();
    chk("rst_restart_fs", 32'(frame_start), 32'd1);

    // Randomized en bursts
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      tick();
    end

    en = 1'b0;
    run(FT + 2);
    chk("final_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
